// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full adder reused across WIDTH clocks, LSB first,
// with a start/busy/done handshake around the operand and result shift registers.

module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one operand bit pair added per cycle, LSB first
// DONE  | one-cycle done pulse; sum/cout/ovf valid
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, sum_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             last_bit;

    serial_add_fa u_fa (
        .a  (ra[0]),
        .b  (rb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Written as shift-then-overwrite so WIDTH=1 needs no zero-width slice.
    always_comb begin
        sum_shift            = sum >> 1;
        sum_shift[WIDTH-1]   = fa_s;
        last_bit             = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    sum   <= sum_shift;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    // Carry entering the MSB is the current carry; resolve flags as DONE begins.
                    if (last_bit) begin
                        cout <= fa_co;
                        ovf  <= carry ^ fa_co;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH 8, 1 and 13 with a scoreboard queue
// of expected results and an arithmetic reference model.

module tb_serial_add_ctrl;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_x = 1'b0;
    logic        sub_in = 1'b0, cin_in = 1'b0;
    logic [31:0] a_in = '0, b_in = '0;
    int          sel = 0;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy1, done1, cout1, ovf1;
    logic [0:0]  sum1;
    logic        busy13, done13, cout13, ovf13;
    logic [12:0] sum13;

    logic        obs_busy, obs_done, obs_cout, obs_ovf;
    logic [31:0] obs_sum;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_x && sel == 0), .sub(sub_in), .cin(cin_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );
    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_x && sel == 1), .sub(sub_in), .cin(cin_in),
        .a(a_in[0:0]), .b(b_in[0:0]), .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .ovf(ovf1)
    );
    serial_add_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start_x && sel == 2), .sub(sub_in), .cin(cin_in),
        .a(a_in[12:0]), .b(b_in[12:0]), .busy(busy13), .done(done13), .sum(sum13),
        .cout(cout13), .ovf(ovf13)
    );

    always_comb begin
        obs_busy = 1'b0; obs_done = 1'b0; obs_cout = 1'b0; obs_ovf = 1'b0; obs_sum = '0;
        case (sel)
            0: begin obs_busy = busy8;  obs_done = done8;  obs_cout = cout8;  obs_ovf = ovf8;  obs_sum = 32'(sum8);  end
            1: begin obs_busy = busy1;  obs_done = done1;  obs_cout = cout1;  obs_ovf = ovf1;  obs_sum = 32'(sum1);  end
            default: begin obs_busy = busy13; obs_done = done13; obs_cout = cout13; obs_ovf = ovf13; obs_sum = 32'(sum13); end
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 0) ? 8 : (s == 1) ? 1 : 13;
    endfunction

    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic sv, input logic cv);
        logic [63:0] mask, m1, aa, bb, full, low, c0;
        exp_t r;
        mask = (64'd1 << w) - 64'd1;
        m1   = mask >> 1;
        aa   = {32'd0, av} & mask;
        bb   = (sv ? ~{32'd0, bv} : {32'd0, bv}) & mask;
        c0   = sv ? 64'd1 : {63'd0, cv};
        full = aa + bb + c0;
        low  = (aa & m1) + (bb & m1) + c0;
        r.sum  = full[31:0] & mask[31:0];
        r.cout = full[w];
        r.ovf  = low[w-1] ^ full[w];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Issue one operation; optionally pulse start in the 3rd RUN cycle and in DONE.
    task automatic do_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic cv, input exp_t e, input bit inject);
        int   w, n, nbusy;
        exp_t want;
        w = width_of(s);
        sel = s; a_in = av; b_in = bv; sub_in = sv; cin_in = cv; start_x = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start_x = 1'b0; a_in = $urandom; b_in = $urandom; sub_in = 1'($urandom); cin_in = 1'($urandom);
        n = 0; nbusy = 0;
        while (obs_done !== 1'b1 && n < w + 4) begin
            if (obs_busy === 1'b1) nbusy++;
            if (inject && n == 2) begin start_x = 1'b1; a_in = ~av; end
            else start_x = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(obs_done), 32'd1);
        chk("run_len", n, w);
        chk("busy_len", nbusy, w);
        chk("busy_done_excl", 32'(obs_busy), 32'd0);
        want = exp_q.pop_front();
        chk("sum", obs_sum, want.sum);
        chk("cout", 32'(obs_cout), 32'(want.cout));
        chk("ovf", 32'(obs_ovf), 32'(want.ovf));
        start_x = inject; a_in = ~av; b_in = ~bv;
        @(posedge clk); #1;
        start_x = 1'b0;
        chk("done_pulse", 32'(obs_done), 32'd0);
        chk("busy_idle", 32'(obs_busy), 32'd0);
        chk("sum_hold", obs_sum, want.sum);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs, rc;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("rst_busy", 32'(obs_busy), 32'd0);
            chk("rst_done", 32'(obs_done), 32'd0);
            chk("rst_sum", obs_sum, 32'd0);
            chk("rst_cout", 32'(obs_cout), 32'd0);
            chk("rst_ovf", 32'(obs_ovf), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(0, 32'h5A, 32'h3C, 1'b0, 1'b0, '{sum: 32'h96, cout: 1'b0, ovf: 1'b1}, 1'b0);
        do_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, '{sum: 32'h00, cout: 1'b1, ovf: 1'b0}, 1'b0);
        do_op(0, 32'h00, 32'h00, 1'b0, 1'b1, '{sum: 32'h01, cout: 1'b0, ovf: 1'b0}, 1'b0);
        do_op(0, 32'h10, 32'h20, 1'b1, 1'b0, '{sum: 32'hF0, cout: 1'b0, ovf: 1'b0}, 1'b0);
        do_op(0, 32'h80, 32'h01, 1'b1, 1'b1, '{sum: 32'h7F, cout: 1'b1, ovf: 1'b1}, 1'b0);

        // Ignored start pulses, then an immediate back-to-back accept.
        do_op(0, 32'h33, 32'h44, 1'b0, 1'b0, '{sum: 32'h77, cout: 1'b0, ovf: 1'b0}, 1'b1);
        do_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, '{sum: 32'h80, cout: 1'b0, ovf: 1'b1}, 1'b0);

        // Reset in the 4th RUN cycle, then a fresh start right after.
        sel = 0; a_in = 32'hFF; b_in = 32'h00; sub_in = 1'b0; cin_in = 1'b1; start_x = 1'b1;
        @(posedge clk); #1;
        start_x = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(obs_busy), 32'd0);
        chk("mid_rst_done", 32'(obs_done), 32'd0);
        chk("mid_rst_sum", obs_sum, 32'd0);
        chk("mid_rst_cout", 32'(obs_cout), 32'd0);
        chk("mid_rst_ovf", 32'(obs_ovf), 32'd0);
        do_op(0, 32'h0F, 32'h01, 1'b0, 1'b0, '{sum: 32'h10, cout: 1'b0, ovf: 1'b0}, 1'b0);

        do_op(1, 32'h1, 32'h1, 1'b0, 1'b1, '{sum: 32'h1, cout: 1'b1, ovf: 1'b0}, 1'b0);
        do_op(1, 32'h0, 32'h1, 1'b1, 1'b0, '{sum: 32'h1, cout: 1'b0, ovf: 1'b1}, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & 32'hFF; rb = $urandom & 32'hFF;
            rs = 1'($urandom); rc = 1'($urandom);
            do_op(0, ra, rb, rs, rc, model(8, ra, rb, rs, rc), 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & 32'h1FFF; rb = $urandom & 32'h1FFF;
            rs = 1'($urandom); rc = 1'($urandom);
            do_op(2, ra, rb, rs, rc, model(13, ra, rb, rs, rc), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
